time_set_ctrl: RTL and testbench

Time-setting controller between the raw button/switch inputs and the `times` counter block.
- Synchronizes `buttons` and the edit switch.
- Turns button presses into single-cycle inc/dec pulses, with hold-to-auto-repeat.
- Exits edit mode after an idle timeout.
- Drives field-select and blink strobes for the text-VFD formatter.
- Replaces level-held inc/dec requests in the watch top level.

---
 rtl/watch_pkg.sv | 88 ++++++++
 rtl/sync2.sv | 27 ++
 rtl/time_set_ctrl.sv | 248 ++++++++++++++++++++++++
 tb/tb_time_set_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/watch_pkg.sv
// Shared types and helpers for the watch time-setting path: FSM states,
// display field codes, button indices and the button-to-pulse mapping.
package watch_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    EDIT   = 3'd1,
    HOLD   = 3'd2,
    REPEAT = 3'd3,
    LOCK   = 3'd4
  } state_e;

  localparam logic [2:0] FIELD_NONE = 3'd0;
  localparam logic [2:0] FIELD_AP   = 3'd1;
  localparam logic [2:0] FIELD_HOUR = 3'd2;
  localparam logic [2:0] FIELD_MIN  = 3'd3;
  localparam logic [2:0] FIELD_SEC  = 3'd4;

  localparam logic [2:0] BTN_AP   = 3'd0;
  localparam logic [2:0] BTN_H_UP = 3'd1;
  localparam logic [2:0] BTN_M_UP = 3'd2;
  localparam logic [2:0] BTN_S_UP = 3'd3;
  localparam logic [2:0] BTN_EXIT = 3'd4;
  localparam logic [2:0] BTN_H_DN = 3'd5;
  localparam logic [2:0] BTN_M_DN = 3'd6;
  localparam logic [2:0] BTN_S_DN = 3'd7;

  // Bit positions inside the packed pulse vector.
  localparam int P_IA = 0;
  localparam int P_IH = 1;
  localparam int P_IM = 2;
  localparam int P_IS = 3;
  localparam int P_DH = 4;
  localparam int P_DM = 5;
  localparam int P_DS = 6;

  // Priority pick among the mapped buttons: {valid, index}.
  function automatic logic [3:0] pick_btn(input logic [7:0] b);
    logic [3:0] r;
    if (b[BTN_AP]) begin
      r = {1'b1, BTN_AP};
    end else if (b[BTN_H_UP]) begin
      r = {1'b1, BTN_H_UP};
    end else if (b[BTN_H_DN]) begin
      r = {1'b1, BTN_H_DN};
    end else if (b[BTN_M_UP]) begin
      r = {1'b1, BTN_M_UP};
    end else if (b[BTN_M_DN]) begin
      r = {1'b1, BTN_M_DN};
    end else if (b[BTN_S_UP]) begin
      r = {1'b1, BTN_S_UP};
    end else if (b[BTN_S_DN]) begin
      r = {1'b1, BTN_S_DN};
    end else begin
      r = 4'd0;
    end
    return r;
  endfunction

  function automatic logic [6:0] btn_pulse(input logic [2:0] idx);
    logic [6:0] r;
    r = 7'd0;
    case (idx)
      BTN_AP:   r[P_IA] = 1'b1;
      BTN_H_UP: r[P_IH] = 1'b1;
      BTN_M_UP: r[P_IM] = 1'b1;
      BTN_S_UP: r[P_IS] = 1'b1;
      BTN_H_DN: r[P_DH] = 1'b1;
      BTN_M_DN: r[P_DM] = 1'b1;
      BTN_S_DN: r[P_DS] = 1'b1;
      default:  r = 7'd0;
    endcase
    return r;
  endfunction

  function automatic logic [2:0] btn_field(input logic [2:0] idx);
    logic [2:0] r;
    case (idx)
      BTN_AP:             r = FIELD_AP;
      BTN_H_UP, BTN_H_DN: r = FIELD_HOUR;
      BTN_M_UP, BTN_M_DN: r = FIELD_MIN;
      BTN_S_UP, BTN_S_DN: r = FIELD_SEC;
      default:            r = FIELD_NONE;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sync2.sv
// Parameterised-width two-flop synchronizer for asynchronous level inputs.
module sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  // Two-stage capture of the raw input.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/time_set_ctrl.sv
// Time-setting controller: button presses become single-cycle inc/dec pulses
// with hold-to-repeat, idle lockout and blink strobe. SET_CTRL_ACCEL_EN adds repeat acceleration.
module time_set_ctrl
  import watch_pkg::*;
#(
  parameter int REPEAT_DELAY = 50,
  parameter int REPEAT_RATE  = 10,
  parameter int IDLE_TIMEOUT = 3000,
  parameter int BLINK_HALF   = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       edit_sw,
  input  logic [7:0] buttons,
  output logic       i_a,
  output logic       i_h,
  output logic       i_m,
  output logic       i_s,
  output logic       d_h,
  output logic       d_m,
  output logic       d_s,
  output logic       editing,
  output logic [2:0] field,
  output logic       blink
);

  localparam int RW = $clog2(REPEAT_DELAY + REPEAT_RATE + 1);
  localparam int IW = $clog2(IDLE_TIMEOUT + 1);
  localparam int BW = $clog2(BLINK_HALF + 1);

  localparam logic [RW-1:0] DLY_C   = RW'(REPEAT_DELAY);
  localparam logic [RW-1:0] RATE_C  = RW'(REPEAT_RATE);
  localparam logic [IW-1:0] IDLE_C  = IW'(IDLE_TIMEOUT);
  localparam logic [BW-1:0] BLINK_C = BW'(BLINK_HALF);

  logic [7:0]    btn_s;
  logic          edit_s;
  logic [3:0]    pick_s;
  logic          held_s;

  state_e        state_q, state_d;
  logic [2:0]    btn_q, btn_d;
  logic [2:0]    field_q, field_d;
  logic [RW-1:0] rep_q, rep_d;
  logic [IW-1:0] idle_q, idle_d;
  logic [BW-1:0] blk_cnt_q, blk_cnt_d;
  logic          blink_q, blink_d;
  logic          editing_q, editing_d;
  logic [6:0]    pulse_q, pulse_d;

  logic [RW-1:0] rep_rate_s;
  logic [RW-1:0] rep_term_s;
  logic [RW-1:0] rep_inc_s;
  logic [IW-1:0] idle_inc_s;
  logic [BW-1:0] blk_inc_s;

  sync2 #(.W(8)) u_sync_btn (
    .clk (clk),
    .rst (rst),
    .d   (buttons),
    .q   (btn_s)
  );

  sync2 #(.W(1)) u_sync_edit (
    .clk (clk),
    .rst (rst),
    .d   (edit_sw),
    .q   (edit_s)
  );

`ifdef SET_CTRL_ACCEL_EN
  localparam int            FAST_I = (REPEAT_RATE / 4 < 1) ? 1 : REPEAT_RATE / 4;
  localparam logic [RW-1:0] FAST_C = RW'(FAST_I);

  logic [3:0] acc_q, acc_d;

  // Counts auto-repeat pulses within one hold; cleared once the hold ends.
  always_comb begin
    acc_d = acc_q;
    if (state_d != HOLD && state_d != REPEAT) begin
      acc_d = 4'd0;
    end else if ((state_q == HOLD || state_q == REPEAT) && pulse_d != 7'd0 && acc_q != 4'd8) begin
      acc_d = acc_q + 4'd1;
    end else begin
      acc_d = acc_q;
    end
  end

  // Acceleration counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q <= 4'd0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign rep_rate_s = (acc_q >= 4'd8) ? FAST_C : RATE_C;
`else
  assign rep_rate_s = RATE_C;
`endif

  // Saturating increments and the active repeat terminal value.
  always_comb begin
    pick_s     = pick_btn(btn_s);
    held_s     = btn_s[btn_q];
    rep_term_s = (state_q == HOLD) ? DLY_C : rep_rate_s;
    rep_inc_s  = (rep_q >= rep_term_s) ? rep_q : rep_q + RW'(1);
    idle_inc_s = (idle_q >= IDLE_C) ? idle_q : idle_q + IW'(1);
    blk_inc_s  = (blk_cnt_q >= BLINK_C) ? blk_cnt_q : blk_cnt_q + BW'(1);
  end

  // Next-state, pulse and field logic.
  always_comb begin
    state_d = state_q;
    btn_d   = btn_q;
    field_d = field_q;
    rep_d   = rep_q;
    idle_d  = idle_q;
    pulse_d = 7'd0;
    case (state_q)
      IDLE: begin
        field_d = FIELD_NONE;
        rep_d   = '0;
        idle_d  = '0;
        if (edit_s) begin
          state_d = EDIT;
        end else begin
          state_d = IDLE;
        end
      end
      EDIT: begin
        if (!edit_s) begin
          state_d = IDLE;
          field_d = FIELD_NONE;
        end else if (pick_s[3]) begin
          btn_d   = pick_s[2:0];
          pulse_d = btn_pulse(pick_s[2:0]);
          field_d = btn_field(pick_s[2:0]);
          rep_d   = '0;
          idle_d  = '0;
          state_d = HOLD;
        end else if (btn_s[BTN_EXIT]) begin
          state_d = LOCK;
        end else if (tick) begin
          idle_d = idle_inc_s;
          if (idle_inc_s >= IDLE_C) begin
            state_d = LOCK;
          end else begin
            state_d = EDIT;
          end
        end else begin
          state_d = EDIT;
        end
      end
      HOLD, REPEAT: begin
        if (!edit_s) begin
          state_d = IDLE;
          field_d = FIELD_NONE;
        end else if (!held_s) begin
          state_d = EDIT;
          idle_d  = '0;
        end else if (tick && btn_q != BTN_AP) begin
          // Am/pm toggles once per press; only the other fields auto-repeat.
          if (rep_inc_s >= rep_term_s) begin
            pulse_d = btn_pulse(btn_q);
            rep_d   = '0;
            state_d = REPEAT;
          end else begin
            rep_d = rep_inc_s;
          end
        end else begin
          state_d = state_q;
        end
      end
      LOCK: begin
        field_d = FIELD_NONE;
        if (!edit_s) begin
          state_d = IDLE;
        end else begin
          state_d = LOCK;
        end
      end
      default: begin
        state_d = IDLE;
        field_d = FIELD_NONE;
      end
    endcase
    editing_d = (state_d == EDIT) || (state_d == HOLD) || (state_d == REPEAT);
  end

  // Blink phase: runs only while editing, snaps visible on each pulse.
  always_comb begin
    blk_cnt_d = blk_cnt_q;
    blink_d   = blink_q;
    if (!editing_d || pulse_d != 7'd0) begin
      blk_cnt_d = '0;
      blink_d   = 1'b1;
    end else if (tick) begin
      if (blk_inc_s >= BLINK_C) begin
        blk_cnt_d = '0;
        blink_d   = ~blink_q;
      end else begin
        blk_cnt_d = blk_inc_s;
      end
    end else begin
      blk_cnt_d = blk_cnt_q;
    end
  end

  // State, counter and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      btn_q     <= 3'd0;
      field_q   <= FIELD_NONE;
      rep_q     <= '0;
      idle_q    <= '0;
      blk_cnt_q <= '0;
      blink_q   <= 1'b1;
      editing_q <= 1'b0;
      pulse_q   <= 7'd0;
    end else begin
      state_q   <= state_d;
      btn_q     <= btn_d;
      field_q   <= field_d;
      rep_q     <= rep_d;
      idle_q    <= idle_d;
      blk_cnt_q <= blk_cnt_d;
      blink_q   <= blink_d;
      editing_q <= editing_d;
      pulse_q   <= pulse_d;
    end
  end

  assign i_a     = pulse_q[P_IA];
  assign i_h     = pulse_q[P_IH];
  assign i_m     = pulse_q[P_IM];
  assign i_s     = pulse_q[P_IS];
  assign d_h     = pulse_q[P_DH];
  assign d_m     = pulse_q[P_DM];
  assign d_s     = pulse_q[P_DS];
  assign editing = editing_q;
  assign field   = field_q;
  assign blink   = blink_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed bench for time_set_ctrl: REPEAT_DELAY=5, REPEAT_RATE=2,
// IDLE_TIMEOUT=20, BLINK_HALF=3, tick on every 4th clock edge.
module tb_time_set_ctrl;

  logic       clk;
  logic       rst;
  logic       tick;
  logic       edit_sw;
  logic [7:0] buttons;
  logic       i_a, i_h, i_m, i_s, d_h, d_m, d_s;
  logic       editing;
  logic [2:0] field;
  logic       blink;

  int n_tests;
  int n_fail;

  int cyc;
  int c_ia, c_ih, c_im, c_is, c_dh, c_dm, c_ds;
  int multi_viol, blink_viol;
  int dm_time[$];

  time_set_ctrl #(
    .REPEAT_DELAY (5),
    .REPEAT_RATE  (2),
    .IDLE_TIMEOUT (20),
    .BLINK_HALF   (3)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .tick    (tick),
    .edit_sw (edit_sw),
    .buttons (buttons),
    .i_a     (i_a),
    .i_h     (i_h),
    .i_m     (i_m),
    .i_s     (i_s),
    .d_h     (d_h),
    .d_m     (d_m),
    .d_s     (d_s),
    .editing (editing),
    .field   (field),
    .blink   (blink)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Edge counter, pulse counters and per-cycle pulse sanity.
  initial begin
    cyc = 0;
    c_ia = 0; c_ih = 0; c_im = 0; c_is = 0; c_dh = 0; c_dm = 0; c_ds = 0;
    multi_viol = 0;
    blink_viol = 0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if ($countones({i_a, i_h, i_m, i_s, d_h, d_m, d_s}) > 1) multi_viol++;
      if ({i_a, i_h, i_m, i_s, d_h, d_m, d_s} != 7'd0 && !blink) blink_viol++;
      if (i_a) c_ia++;
      if (i_h) c_ih++;
      if (i_m) c_im++;
      if (i_s) c_is++;
      if (d_h) c_dh++;
      if (d_m) begin
        c_dm++;
        dm_time.push_back(cyc);
      end
      if (d_s) c_ds++;
    end
  end

  // Tick is high for clock edges whose number is a multiple of 4.
  initial begin
    tick = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      tick = ((cyc + 1) % 4 == 0);
    end
  end

  task automatic check_val(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Returns at a negedge such that the next edge n satisfies n % 4 == 1.
  task automatic align();
    do @(negedge clk); while ((cyc + 1) % 4 != 1);
  endtask

  int b0, b1, q0;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b1;
    edit_sw = 1'b0;
    buttons = 8'h00;
    #2 rst = 1'b0;
    wait_clks(3);
    check_val("rst_editing", int'(editing), 0);
    check_val("rst_field", int'(field), 0);
    check_val("rst_blink", int'(blink), 1);
    check_val("rst_pulses", int'({i_a, i_h, i_m, i_s, d_h, d_m, d_s}), 0);
    rst = 1'b1;
    wait_clks(4);
    check_val("idle_editing", int'(editing), 0);

    edit_sw = 1'b1;
    wait_clks(6);
    check_val("enter_edit", int'(editing), 1);
    check_val("enter_field", int'(field), 0);

    // 1: short press of hour-up, pulse three edges after first sample.
    align();
    buttons = 8'h02;
    b0 = c_ih;
    @(posedge clk); #1;
    check_val("t1_lat0", int'(i_h), 0);
    @(posedge clk); #1;
    check_val("t1_lat1", int'(i_h), 0);
    @(posedge clk); #1;
    check_val("t1_lat2", int'(i_h), 1);
    check_val("t1_field_now", int'(field), 2);
    wait_clks(9);
    buttons = 8'h00;
    wait_clks(10);
    check_val("t1_count", c_ih - b0, 1);
    check_val("t1_field", int'(field), 2);

    // 2: hold min-down 232 clocks: press pulse, +17 clk, then every 8 clk -> 28.
    align();
    buttons = 8'h40;
    b0 = c_dm;
    q0 = dm_time.size();
    wait_clks(232);
    buttons = 8'h00;
    wait_clks(10);
    check_val("t2_count", c_dm - b0, 28);
    check_val("t2_field", int'(field), 3);
    if (dm_time.size() >= q0 + 28) begin
      check_val("t2_gap_first", dm_time[q0 + 1] - dm_time[q0], 17);
      check_val("t2_gap_second", dm_time[q0 + 2] - dm_time[q0 + 1], 8);
      check_val("t2_gap_last", dm_time[q0 + 27] - dm_time[q0 + 26], 8);
    end

    // 3: am/pm never repeats.
    align();
    buttons = 8'h01;
    b0 = c_ia;
    wait_clks(240);
    buttons = 8'h00;
    wait_clks(10);
    check_val("t3_count", c_ia - b0, 1);
    check_val("t3_field", int'(field), 1);

    // 4: sec-up and sec-down together: sec-up wins.
    align();
    buttons = 8'h88;
    b0 = c_is;
    b1 = c_ds;
    wait_clks(11);
    buttons = 8'h00;
    wait_clks(10);
    check_val("t4_is", c_is - b0, 1);
    check_val("t4_ds", c_ds - b1, 0);
    check_val("t4_field", int'(field), 4);

    // 5: idle lockout 20 ticks after re-entering EDIT (release edge r, lock at r+80).
    wait_clks(65);
    check_val("t5_still_edit", int'(editing), 1);
    wait_clks(10);
    check_val("t5_locked", int'(editing), 0);
    check_val("t5_field", int'(field), 0);
    check_val("t5_blink", int'(blink), 1);
    buttons = 8'h04;
    b0 = c_im;
    wait_clks(12);
    buttons = 8'h00;
    wait_clks(5);
    check_val("t5_no_pulse", c_im - b0, 0);
    edit_sw = 1'b0;
    wait_clks(5);
    edit_sw = 1'b1;
    wait_clks(6);
    check_val("t5_reenter", int'(editing), 1);
    check_val("t5_reenter_field", int'(field), 0);

    // Edit switch dropped while holding: no more pulses, field cleared.
    align();
    buttons = 8'h02;
    b0 = c_ih;
    wait_clks(8);
    edit_sw = 1'b0;
    wait_clks(40);
    check_val("sw_off_count", c_ih - b0, 1);
    check_val("sw_off_editing", int'(editing), 0);
    check_val("sw_off_field", int'(field), 0);
    buttons = 8'h00;
    edit_sw = 1'b1;
    wait_clks(6);

    // 6: asynchronous reset in the middle of auto-repeat.
    align();
    buttons = 8'h20;
    b0 = c_dh;
    wait_clks(40);
    check_val("t6_repeating", (c_dh - b0 >= 3) ? 1 : 0, 1);
    check_val("t6_pre_field", int'(field), 2);
    #1 rst = 1'b0;
    #1;
    check_val("t6_editing", int'(editing), 0);
    check_val("t6_field", int'(field), 0);
    check_val("t6_blink", int'(blink), 1);
    check_val("t6_pulses", int'({i_a, i_h, i_m, i_s, d_h, d_m, d_s}), 0);
    buttons = 8'h00;
    wait_clks(2);
    rst = 1'b1;
    wait_clks(6);
    check_val("t6_recover", int'(editing), 1);

    check_val("onehot_pulses", multi_viol, 0);
    check_val("blink_on_pulse", blink_viol, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
